// File: rtl/pic_param_ctrl.sv
// pic_param_ctrl: parametrised programmable interrupt controller.
//
// Ports:
//   clk, reset    - single clock, synchronous active-high reset
//   irq           - NUM_IRQ request lines, synchronous to clk
//   wr_en/addr/wr_data - register writes (0 IMR, 1 base, 2 CTRL, 3 EOI command)
//   rd_en/addr/rd_data - register reads (0 IMR, 1 base, 2 IRR, 3 ISR); rd_data is registered
//   int_out       - interrupt request to the CPU
//   inta          - acknowledge pulses from the CPU (two per handshake)
//   vector_out    - base + winning index, qualified by the one-cycle vector_valid
module pic_param_ctrl #(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned VEC_W   = 8,
  parameter int unsigned DATA_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               wr_en,
  input  logic [1:0]         addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               rd_en,
  output logic [DATA_W-1:0]  rd_data,
  output logic               int_out,
  input  logic               inta,
  output logic [VEC_W-1:0]   vector_out,
  output logic               vector_valid
);

  localparam int unsigned IDX_W = $clog2(NUM_IRQ);
  localparam int unsigned PW    = IDX_W + 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_IRQ - 1);

  typedef enum logic [1:0] {StIdle, StPend, StAck1} state_e;

  state_e               state_q, state_d;
  logic [NUM_IRQ-1:0]   imr_q, imr_d, irr_q, irr_d, isr_q, isr_d, irq_q;
  logic [VEC_W-1:0]     base_q, base_d, vector_out_q, vector_out_d;
  logic [2:0]           ctrl_q, ctrl_d;  // bit0 level, bit1 rotate, bit2 auto-EOI
  logic [IDX_W-1:0]     ptr_q, ptr_d, idx_q, idx_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;
  logic                 int_out_q, int_out_d, vector_valid_q, vector_valid_d;

  // Arbitration results
  logic [NUM_IRQ-1:0]   cand;
  logic                 win_valid, blocked, isr_valid;
  logic [IDX_W-1:0]     win_idx, isr_top, pos;
  logic [PW-1:0]        pos_w;

  // Next-state helpers
  logic [NUM_IRQ-1:0]   eoi_clr, set_bit, irr_clr;
  logic [IDX_W-1:0]     lvl;

  logic unused_wr_data;
  assign unused_wr_data = ^wr_data;

  // Walk the ring from pointer+1. The first set ISR bit met blocks every lower-ranked
  // candidate (fully nested); it is also the target of a non-specific EOI.
  always_comb begin
    cand      = irr_q & ~imr_q;
    win_valid = 1'b0;
    win_idx   = '0;
    blocked   = 1'b0;
    isr_valid = 1'b0;
    isr_top   = '0;
    pos_w     = '0;
    pos       = '0;
    for (int unsigned k = 0; k < NUM_IRQ; k++) begin
      pos_w = {1'b0, ptr_q} + PW'(k + 1);
      if (pos_w >= PW'(NUM_IRQ)) pos_w = pos_w - PW'(NUM_IRQ);
      pos = pos_w[IDX_W-1:0];
      if (!blocked && !win_valid) begin
        if (isr_q[pos]) begin
          blocked = 1'b1;
        end else if (cand[pos]) begin
          win_valid = 1'b1;
          win_idx   = pos;
        end
      end
      if (!isr_valid && isr_q[pos]) begin
        isr_valid = 1'b1;
        isr_top   = pos;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    imr_d          = imr_q;
    base_d         = base_q;
    ctrl_d         = ctrl_q;
    ptr_d          = ptr_q;
    idx_d          = idx_q;
    rd_data_d      = rd_data_q;
    int_out_d      = int_out_q;
    vector_out_d   = vector_out_q;
    vector_valid_d = 1'b0;
    eoi_clr        = '0;
    set_bit        = '0;
    irr_clr        = '0;
    lvl            = wr_data[IDX_W-1:0];

    if (wr_en) begin
      unique case (addr)
        2'd0: imr_d  = wr_data[NUM_IRQ-1:0];
        2'd1: base_d = wr_data[VEC_W-1:0];
        2'd2: ctrl_d = wr_data[2:0];
        default: begin
          if (wr_data[8]) begin
            if ({1'b0, lvl} < PW'(NUM_IRQ)) begin
              eoi_clr[lvl] = 1'b1;
              if (ctrl_q[1]) ptr_d = lvl;
            end
          end else if (isr_valid) begin
            eoi_clr[isr_top] = 1'b1;
            if (ctrl_q[1]) ptr_d = isr_top;
          end
        end
      endcase
    end

    if (rd_en) begin
      rd_data_d = '0;
      unique case (addr)
        2'd0: rd_data_d[NUM_IRQ-1:0] = imr_q;
        2'd1: rd_data_d[VEC_W-1:0]   = base_q;
        2'd2: rd_data_d[NUM_IRQ-1:0] = irr_q;
        default: rd_data_d[NUM_IRQ-1:0] = isr_q;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d   = StPend;
          int_out_d = 1'b1;
        end
      end
      StPend: begin
        if (inta) begin
          state_d   = StAck1;
          int_out_d = 1'b0;
          if (win_valid) begin
            idx_d = win_idx;
            if (!ctrl_q[2]) set_bit[win_idx] = 1'b1;
            if (!ctrl_q[0]) irr_clr[win_idx] = 1'b1;
          end else begin
            // Request vanished between INT and INTA: spurious vector, ISR untouched
            idx_d = LastIdx;
          end
        end
      end
      StAck1: begin
        int_out_d = 1'b0;
        if (inta) begin
          state_d        = StIdle;
          vector_out_d   = base_q + VEC_W'(idx_q);
          vector_valid_d = 1'b1;
          if (ctrl_q[2] && ctrl_q[1]) ptr_d = idx_q;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!ctrl_q[1]) ptr_d = LastIdx;

    if (ctrl_q[0]) irr_d = irq;
    else           irr_d = (irr_q & ~irr_clr) | (irq & ~irq_q);

    isr_d = (isr_q & ~eoi_clr) | set_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      imr_q          <= '1;
      base_q         <= '0;
      ctrl_q         <= '0;
      irr_q          <= '0;
      isr_q          <= '0;
      irq_q          <= '0;
      ptr_q          <= LastIdx;
      idx_q          <= '0;
      rd_data_q      <= '0;
      int_out_q      <= 1'b0;
      vector_out_q   <= '0;
      vector_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      imr_q          <= imr_d;
      base_q         <= base_d;
      ctrl_q         <= ctrl_d;
      irr_q          <= irr_d;
      isr_q          <= isr_d;
      irq_q          <= irq;
      ptr_q          <= ptr_d;
      idx_q          <= idx_d;
      rd_data_q      <= rd_data_d;
      int_out_q      <= int_out_d;
      vector_out_q   <= vector_out_d;
      vector_valid_q <= vector_valid_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign int_out      = int_out_q;
  assign vector_out   = vector_out_q;
  assign vector_valid = vector_valid_q;

endmodule

// File: doc/pic_param_ctrl.md
Name: pic_param_ctrl

Overview:
- Parametrised, clocked successor to the 8-input programmable interrupt controller.
- Supports NUM_IRQ request lines, with edge or level triggering selected per controller.
- Priority is fixed or rotating, with optional auto-EOI and a VEC_W-bit vector base.
- Sits between peripheral IRQ lines and the CPU: simple register port for programming and status, plus a two-pulse INT/INTA handshake that returns the vector.

Parameters:
- NUM_IRQ, 8, number of request inputs (2..32).
- VEC_W, 8, vector width (1..32).
- DATA_W, 32, register port width; must be >= NUM_IRQ and >= VEC_W.
- IDX_W, $clog2(NUM_IRQ), index width (derived, not overridden).

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high.
- irq  in  NUM_IRQ  interrupt request lines, synchronous to clk.
- wr_en  in  1  register write strobe.
- addr  in  2  register select for reads and writes.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  register read strobe.
- rd_data  out  DATA_W  registered read data.
- int_out  out  1  interrupt request to CPU.
- inta  in  1  acknowledge pulse from CPU, one cycle per pulse.
- vector_out  out  VEC_W  interrupt vector.
- vector_valid  out  1  one-cycle qualifier for vector_out.

Behaviour:
- Interface rule: one clock; reset is synchronous and active-high.
- Register map, writes:
  - addr 0: IMR.
  - addr 1: vector base, wr_data[VEC_W-1:0].
  - addr 2: CTRL. bit0 = level mode, bit1 = rotating priority, bit2 = auto-EOI.
  - addr 3: EOI command. bit8 = specific; bits[IDX_W-1:0] = level when specific.
- Register map, reads (rd_data valid the cycle after rd_en; otherwise holds its last value):
  - addr 0: IMR.
  - addr 1: base.
  - addr 2: IRR.
  - addr 3: ISR.
  - Unused high bits read 0.
- Reset values:
  - IMR all ones; base 0; CTRL 0; IRR 0; ISR 0; irq_q 0.
  - Rotation pointer = NUM_IRQ-1, so index 0 is highest priority.
  - rd_data 0, int_out 0, vector_out 0, vector_valid 0, FSM IDLE.
  - Reset mid-handshake aborts it: no vector is issued.
- IRR:
  - Edge mode: bit set on irq & ~irq_q; cleared when its bit is acknowledged on the first INTA.
  - Level mode: IRR = irq every cycle.
  - Masked bits stay latched in IRR but are not presented for priority.
- Priority:
  - Candidates = IRR & ~IMR.
  - Search starts at (pointer+1) mod NUM_IRQ and wraps.
  - Fixed mode: pointer is held at NUM_IRQ-1.
  - Fully nested: a candidate wins only if it ranks above the highest-priority set ISR bit.
- FSM:
  - IDLE: a winner exists -> PEND; int_out = 1 from the next cycle.
  - PEND, on inta:
    - Latch the winner idx; set ISR[idx] unless auto-EOI; clear IRR[idx] in edge mode; deassert int_out.
    - Go to ACK1.
    - If the winner vanished (e.g. level drop or mask), latch spurious idx NUM_IRQ-1, leave ISR unchanged, go to ACK1.
  - ACK1, on second inta: the next cycle drives vector_out = (base + idx) mod 2^VEC_W with vector_valid = 1 for one cycle, then IDLE. int_out is re-evaluated from IDLE.
  - inta while IDLE: ignored.
- EOI:
  - Specific: clears ISR[level].
  - Non-specific: clears the highest-priority set ISR bit under the current rotation; no-op if ISR = 0.
  - Rotating mode: pointer := cleared index. With auto-EOI, pointer := idx at the second INTA.
- Simultaneous events:
  - ISR_next = (ISR & ~eoi_clr) | set_bit, so EOI and the first INTA in the same cycle both take effect.
  - Register writes take effect the next cycle; arbitration in that cycle uses the old values.
  - A write to IMR during ACK1 does not change the latched idx.

Test Plan:
1. Reset, IMR=0x00, base=0x20, edge mode, pulse irq[3] -> int_out=1 two cycles later. Two inta pulses -> vector_out=0x23 with vector_valid for 1 cycle; ISR=0x08; IRR=0x00.
2. irq[5] and irq[2] together, fixed mode -> vector 0x22 first. irq[5] stays pending, blocked until EOI: non-specific EOI clears ISR bit2, then vector 0x25 is delivered.
3. Rotating mode: service irq1, then EOI -> pointer=1. Then irq0 and irq2 together -> irq2 wins (vector base+2).
4. Level mode: irq[4] high, then dropped before the first inta -> spurious vector base+7 (NUM_IRQ=8) with ISR unchanged.
5. IMR=0x01 with irq[0] pulsed -> int_out stays 0 and IRR reads 0x01. Then write IMR=0 -> int_out asserts.
6. NUM_IRQ=16, VEC_W=4, base=0xF, irq[3] -> vector 0x2 (wrap). Assert reset between the two inta pulses -> vector_valid never asserts and all registers return to reset values.
